// File: rtl/pulse_stretcher_pkg.sv
// Shared types and sizing helpers for the pulse stretcher.
// No logic, so no latency.
// No flow control.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } stretch_state_t;

  // Width of a down-counter that must hold values 0..n-1, never narrower than one bit
  function automatic int cnt_width(int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pulse_stretcher_sat_counter.sv
// Saturating up/down request counter with a one-cycle overflow strobe.
// Latency: count and overflow update on the clock edge after inc/dec.
// No backpressure: an inc at MAX is dropped and flagged on overflow.
module sat_counter #(
  parameter int MAX = 3,
  parameter int W   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         overflow
);

  // Simultaneous inc and dec cancel; overflow is high only for the cycle after a dropped inc
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (inc && !dec) begin
        if (cnt == W'(MAX)) begin
          overflow <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (dec && !inc && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle strobes into HIGH_CYC-wide pulses separated by at least GAP_CYC low cycles.
// Latency: out rises one cycle after the strobe edge; busy/pend_cnt/overflow are registered.
// No backpressure: strobes while busy are queued up to PEND_MAX, beyond that dropped with overflow.
// Build option STRETCH_RETRIGGER_EN: a strobe during the high phase extends the pulse instead of queueing.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int HIGH_CYC = 4,
  parameter int GAP_CYC  = 2,
  parameter int PEND_MAX = 3,
  parameter int PW       = $clog2(PEND_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_pulse,
  output logic          out,
  output logic          busy,
  output logic [PW-1:0] pend_cnt,
  output logic          overflow
);

  localparam int CMAX = (HIGH_CYC > GAP_CYC) ? HIGH_CYC : GAP_CYC;
  localparam int CW   = cnt_width(CMAX);
  localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYC - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYC - 1);

  stretch_state_t state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           q_inc, q_dec;
  logic           pend_nz;

  assign pend_nz = (pend_cnt != '0);

  // Next-state and phase counter; queue inc/dec requests for the pending counter
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    q_inc     = 1'b0;
    q_dec     = 1'b0;
    case (state)
      IDLE: begin
        if (in_pulse) begin
          state_nxt = ACTIVE;
          cnt_nxt   = HIGH_LOAD;
        end
      end
      ACTIVE: begin
`ifdef STRETCH_RETRIGGER_EN
        if (in_pulse) begin
          cnt_nxt = HIGH_LOAD;
        end else if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
`else
        q_inc = in_pulse;
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
`endif
      end
      GAP: begin
        if (cnt == '0) begin
          if (pend_nz || in_pulse) begin
            // A queued request is served first; a coincident new strobe takes its queue slot
            state_nxt = ACTIVE;
            cnt_nxt   = HIGH_LOAD;
            q_dec     = pend_nz;
            q_inc     = in_pulse && pend_nz;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
          q_inc   = in_pulse;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, phase counter and registered busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // Moore output straight from the state register keeps out glitch-free
  assign out = (state == ACTIVE);

  sat_counter #(
    .MAX (PEND_MAX),
    .W   (PW)
  ) u_pend (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (q_inc),
    .dec      (q_dec),
    .cnt      (pend_cnt),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_pulse_stretcher.sv
module tb_pulse_stretcher;

  logic       clk;
  logic       rst_n;
  logic       in_pulse;
  logic       out;
  logic       busy;
  logic [1:0] pend_cnt;
  logic       overflow;

  int n_chk;
  int n_fail;

  typedef struct {
    logic       in;
    logic       out;
    logic       busy;
    logic [1:0] pend;
    logic       ovf;
  } vec_t;

  vec_t tbl[$];

  pulse_stretcher #(
    .HIGH_CYC (4),
    .GAP_CYC  (2),
    .PEND_MAX (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_pulse (in_pulse),
    .out      (out),
    .busy     (busy),
    .pend_cnt (pend_cnt),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic logic w(input int k, input int a, input int b);
    return (k >= a) && (k <= b);
  endfunction

  // Entry k-1 of the table drives the strobe for edge k-1 and holds the expectations for cycle k
  task automatic run_table(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      in_pulse = tbl[i].in;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("%s.c%0d.out", name, i + 1), int'(out), int'(tbl[i].out));
      chk($sformatf("%s.c%0d.busy", name, i + 1), int'(busy), int'(tbl[i].busy));
      chk($sformatf("%s.c%0d.pend", name, i + 1), int'(pend_cnt), int'(tbl[i].pend));
      chk($sformatf("%s.c%0d.ovf", name, i + 1), int'(overflow), int'(tbl[i].ovf));
    end
    in_pulse = 1'b0;
    tbl.delete();
  endtask

  task automatic fill_single();
    vec_t v;
    for (int k = 1; k <= 9; k++) begin
      v.in   = (k == 1);
      v.out  = w(k, 1, 4);
      v.busy = w(k, 1, 6);
      v.pend = 2'd0;
      v.ovf  = 1'b0;
      tbl.push_back(v);
    end
  endtask

  initial begin
    vec_t v;
    n_chk    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    in_pulse = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.out", int'(out), 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.pend", int'(pend_cnt), 0);
    chk("reset.ovf", int'(overflow), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single strobe
    fill_single();
    run_table("t1");

`ifdef STRETCH_RETRIGGER_EN
    // 6: strobes at 0 and 2 extend the pulse
    for (int k = 1; k <= 10; k++) begin
      v.in   = (k == 1) || (k == 3);
      v.out  = w(k, 1, 6);
      v.busy = w(k, 1, 8);
      v.pend = 2'd0;
      v.ovf  = 1'b0;
      tbl.push_back(v);
    end
    run_table("t6");

    // burst of five strobes keeps retriggering, nothing is queued
    for (int k = 1; k <= 11; k++) begin
      v.in   = (k <= 5);
      v.out  = w(k, 1, 8);
      v.busy = w(k, 1, 10);
      v.pend = 2'd0;
      v.ovf  = 1'b0;
      tbl.push_back(v);
    end
    run_table("t3r");
`else
    // 2: strobes at 0 and 2, second one queued
    for (int k = 1; k <= 13; k++) begin
      v.in   = (k == 1) || (k == 3);
      v.out  = w(k, 1, 4) || w(k, 7, 10);
      v.busy = w(k, 1, 12);
      v.pend = w(k, 3, 6) ? 2'd1 : 2'd0;
      v.ovf  = 1'b0;
      tbl.push_back(v);
    end
    run_table("t2");

    // 3: strobes at 0..4, saturation and overflow
    for (int k = 1; k <= 25; k++) begin
      v.in   = (k <= 5);
      v.out  = w(k, 1, 4) || w(k, 7, 10) || w(k, 13, 16) || w(k, 19, 22);
      v.busy = w(k, 1, 24);
      v.pend = (k == 2) ? 2'd1 :
               (k == 3) ? 2'd2 :
               w(k, 4, 6) ? 2'd3 :
               w(k, 7, 12) ? 2'd2 :
               w(k, 13, 18) ? 2'd1 : 2'd0;
      v.ovf  = (k == 5);
      tbl.push_back(v);
    end
    run_table("t3");
`endif

    // 4: second strobe exactly at the GAP terminal is served directly
    for (int k = 1; k <= 13; k++) begin
      v.in   = (k == 1) || (k == 7);
      v.out  = w(k, 1, 4) || w(k, 7, 10);
      v.busy = w(k, 1, 12);
      v.pend = 2'd0;
      v.ovf  = 1'b0;
      tbl.push_back(v);
    end
    run_table("t4");

    // 5: asynchronous reset mid-pulse discards the queued strobe
    in_pulse = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    in_pulse = 1'b0;
    chk("t5.pre.out", int'(out), 1);
    chk("t5.pre.busy", int'(busy), 1);
`ifdef STRETCH_RETRIGGER_EN
    chk("t5.pre.pend", int'(pend_cnt), 0);
`else
    chk("t5.pre.pend", int'(pend_cnt), 1);
`endif
    #1 rst_n = 1'b0;
    #1;
    chk("t5.rst.out", int'(out), 0);
    chk("t5.rst.busy", int'(busy), 0);
    chk("t5.rst.pend", int'(pend_cnt), 0);
    chk("t5.rst.ovf", int'(overflow), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5.post.out", int'(out), 0);
    chk("t5.post.busy", int'(busy), 0);
    fill_single();
    run_table("t5.clean");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
